// File: rtl/bip_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bip_pkg                                                    |
// | Description : Shared constants for the BIP execution controller: bus    |
// |               widths, the halt opcode, the controller state encoding    |
// |               and small state-decode helpers.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package bip_pkg;

    // Bus widths; the opcode occupies the top c_nb_opcode bits of a word.
    localparam int c_nb_data            = 16;
    localparam int c_nb_opcode          = 5;
    localparam int c_log2_n_insmem_addr = 11;
    localparam int c_nb_cycle           = 32;

    localparam logic [c_nb_opcode-1:0] c_hlt_opcode = 5'b00000;

    // Controller state encoding
    localparam int c_nb_state = 3;
    localparam logic [c_nb_state-1:0] c_st_idle      = 3'd0;
    localparam logic [c_nb_state-1:0] c_st_clear     = 3'd1;
    localparam logic [c_nb_state-1:0] c_st_run       = 3'd2;
    localparam logic [c_nb_state-1:0] c_st_step_wait = 3'd3;
    localparam logic [c_nb_state-1:0] c_st_step_exec = 3'd4;
    localparam logic [c_nb_state-1:0] c_st_halt      = 3'd5;

    // States in which the CPU executes an instruction (o_valid high).
    function automatic logic is_exec_state(input logic [c_nb_state-1:0] st);
        return (st == c_st_run) || (st == c_st_step_exec);
    endfunction

    // States in which a program is in progress.
    function automatic logic is_busy_state(input logic [c_nb_state-1:0] st);
        return (st == c_st_clear) || (st == c_st_run) ||
               (st == c_st_step_wait) || (st == c_st_step_exec);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bip_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bip_edge_detect                                            |
// | Description : 1-bit rising-edge detector. o_pulse is high for the cycle |
// |               in which i_sig is high and was low on the previous cycle. |
// | Ports       : clk     - clock                                            |
// |               rst     - synchronous active-high reset                    |
// |               i_sig   - level input                                      |
// |               o_pulse - single-cycle rising-edge pulse                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bip_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~r_sig_q;

endmodule
`default_nettype wire

// File: rtl/bip_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bip_run_ctrl                                               |
// | Description : Execution controller for the BIP CPU. Drives the CPU      |
// |               enable and reset, supports continuous and single-step     |
// |               runs, halts on HLT or on a cycle budget, and reports the  |
// |               executed cycle count and the halt PC.                     |
// | Ports       : i_clock, i_reset    - clock, synchronous active-high reset |
// |               i_start             - level, start / restart a run         |
// |               i_mode              - 0 continuous, 1 single-step          |
// |               i_step              - rising edge executes one step        |
// |               i_abort             - return to IDLE                       |
// |               i_instruction, i_pc - current CPU instruction and PC       |
// |               o_valid, o_cpu_reset- CPU enable and reset                 |
// |               o_busy, o_halted    - run in progress / halted status      |
// |               o_timeout           - halt caused by cycle budget          |
// |               o_cycle_count       - executed cycles since last CLEAR     |
// |               o_halt_pc           - PC captured at the halt event        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bip_run_ctrl
    import bip_pkg::*;
#(
    parameter int                    NB_DATA            = c_nb_data,
    parameter int                    NB_OPCODE          = c_nb_opcode,
    parameter int                    LOG2_N_INSMEM_ADDR = c_log2_n_insmem_addr,
    parameter int                    NB_CYCLE           = c_nb_cycle,
    parameter int unsigned           MAX_CYCLES         = 1000000,
    parameter logic [NB_OPCODE-1:0]  HLT_OPCODE         = c_hlt_opcode
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_mode,
    input  logic                          i_step,
    input  logic                          i_abort,
    input  logic [NB_DATA-1:0]            i_instruction,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
    output logic                          o_valid,
    output logic                          o_cpu_reset,
    output logic                          o_busy,
    output logic                          o_halted,
    output logic                          o_timeout,
    output logic [NB_CYCLE-1:0]           o_cycle_count,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_halt_pc
);

    localparam logic [NB_CYCLE-1:0] c_last_cycle = NB_CYCLE'(MAX_CYCLES - 1);
    localparam logic [NB_CYCLE-1:0] c_one        = NB_CYCLE'(1);

    logic [c_nb_state-1:0]         r_state;
    logic [c_nb_state-1:0]         w_state_nxt;
    logic                          w_step_pulse;
    logic                          w_hlt_seen;
    logic                          w_timeout_hit;
    logic                          w_exec;
    logic                          w_unused_instr_lsbs;

    logic                          r_valid;
    logic                          r_cpu_reset;
    logic                          r_busy;
    logic                          r_halted;
    logic                          r_timeout;
    logic [NB_CYCLE-1:0]           r_count;
    logic [LOG2_N_INSMEM_ADDR-1:0] r_halt_pc;

    // Only the opcode field matters for halt detection.
    assign w_hlt_seen          = (i_instruction[NB_DATA-1 -: NB_OPCODE] == HLT_OPCODE);
    assign w_unused_instr_lsbs = ^i_instruction[NB_DATA-NB_OPCODE-1:0];

    // The count never wraps: the run stops when this compare fires.
    assign w_timeout_hit = (r_count == c_last_cycle);
    assign w_exec        = is_exec_state(r_state);

    bip_edge_detect u_step_edge (
        .clk     (i_clock),
        .rst     (i_reset),
        .i_sig   (i_step),
        .o_pulse (w_step_pulse)
    );

    // Next-state logic. The run mode is captured by the choice between RUN
    // and STEP_WAIT when leaving CLEAR. HLT during CLEAR is ignored since the
    // CPU is held in reset there.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) w_state_nxt = c_st_clear;
            end
            c_st_clear: begin
                w_state_nxt = i_mode ? c_st_step_wait : c_st_run;
            end
            c_st_run: begin
                if (w_hlt_seen || w_timeout_hit) w_state_nxt = c_st_halt;
            end
            c_st_step_wait: begin
                if (w_step_pulse) w_state_nxt = c_st_step_exec;
            end
            c_st_step_exec: begin
                if (w_hlt_seen || w_timeout_hit) w_state_nxt = c_st_halt;
                else                             w_state_nxt = c_st_step_wait;
            end
            c_st_halt: begin
                if (i_start) w_state_nxt = c_st_clear;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        // Abort overrides every other event.
        if (i_abort) w_state_nxt = c_st_idle;
    end

    // State register plus registered outputs. Outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= c_st_idle;
            r_valid     <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_count     <= '0;
            r_halt_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= is_exec_state(w_state_nxt);
            r_cpu_reset <= (w_state_nxt == c_st_clear);
            r_busy      <= is_busy_state(w_state_nxt);
            r_halted    <= (w_state_nxt == c_st_halt);

            if (w_state_nxt == c_st_clear) begin
                r_count   <= '0;
                r_timeout <= 1'b0;
                r_halt_pc <= '0;
            end else if (i_abort) begin
                // Count and halt PC stay visible after an abort.
                r_timeout <= 1'b0;
            end else if (w_exec) begin
                r_count <= r_count + c_one;
                if (w_state_nxt == c_st_halt) begin
                    r_halt_pc <= i_pc;
                    // HLT has priority, so a simultaneous budget hit is not a timeout.
                    r_timeout <= ~w_hlt_seen;
                end
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_cpu_reset   = r_cpu_reset;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_count;
    assign o_halt_pc     = r_halt_pc;

endmodule
`default_nettype wire
